// File: rtl/snn_aer_pkg.sv
// Shared AER definitions for the encoder, router and decoder.
// Address width follows the neuron count; timestamps default to 16 bits.
package snn_aer_pkg;

    localparam int AER_NUM_NEURONS = 256;
    localparam int AER_TS_W        = 16;

    function automatic int aer_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int AER_ID_W = aer_id_width(AER_NUM_NEURONS);

    typedef struct packed {
        logic [AER_ID_W-1:0] id;
        logic [AER_TS_W-1:0] ts;
        logic                last;
    } aer_event_t;

endpackage

// File: rtl/spike_prio_enc.sv
// Combinational lowest-set-bit encoder; idx is 0 when no bit is set.
module spike_prio_enc
    import snn_aer_pkg::*;
#(
    parameter int N = 256,
    parameter int W = aer_id_width(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        idx = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/spike_aer_encoder.sv
// Collects per-timestep spike bitmaps and drains them lowest-ID-first as AER events.
// Tick->first event is 2 edges; 1 event/cycle under ready; payload held while stalled.
module spike_aer_encoder
    import snn_aer_pkg::*;
#(
    parameter int NUM_NEURONS = AER_NUM_NEURONS,
    parameter int ID_W        = aer_id_width(NUM_NEURONS),
    parameter int TS_W        = AER_TS_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_NEURONS-1:0] spike_valid,
    input  logic                   frame_tick,
    input  logic                   cfg_enable,
    output logic                   aer_valid,
    input  logic                   aer_ready,
    output logic [ID_W-1:0]        aer_id,
    output logic [TS_W-1:0]        aer_ts,
    output logic                   aer_last,
    output logic                   busy,
    output logic [31:0]            evt_cnt,
    output logic [15:0]            drop_cnt
);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_SEND = 1'b1;

    logic [NUM_NEURONS-1:0] collect;
    logic [NUM_NEURONS-1:0] drain;
    logic [NUM_NEURONS-1:0] sel_mask;
    logic [NUM_NEURONS-1:0] drain_rest;
    logic [NUM_NEURONS-1:0] frame_bits;
    logic [TS_W-1:0]        ts_cnt;
    logic [TS_W-1:0]        frame_ts;
    logic [ID_W-1:0]        enc_idx;
    logic                   enc_any;
    logic                   state;
    logic                   accept;
    logic                   load_next;
    logic                   frame_close;
    logic                   frame_take;

    spike_prio_enc #(
        .N (NUM_NEURONS),
        .W (ID_W)
    ) u_prio_enc (
        .vec (drain),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_comb begin
        sel_mask          = '0;
        sel_mask[enc_idx] = 1'b1;
    end

    assign drain_rest  = drain & ~sel_mask;
    assign frame_bits  = collect | spike_valid;
    assign accept      = aer_valid && aer_ready;
    assign load_next   = enc_any && ((state == STATE_IDLE) || aer_ready);
    assign frame_close = cfg_enable && frame_tick;
    // A frame is only handed over when nothing from the previous one is in flight.
    assign frame_take  = frame_close && !enc_any && (state == STATE_IDLE);

    assign aer_valid = (state == STATE_SEND);
    assign busy      = enc_any || aer_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collect  <= '0;
            ts_cnt   <= '0;
            frame_ts <= '0;
            drop_cnt <= '0;
        end else if (cfg_enable) begin
            if (frame_tick) begin
                collect <= '0;
                ts_cnt  <= ts_cnt + 1'b1;
                if (frame_take) begin
                    frame_ts <= ts_cnt;
                end else if (frame_bits != '0 && drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end else begin
                collect <= frame_bits;
            end
        end
    end

    // frame_take requires an empty drain and load_next a non-empty one, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain    <= '0;
            state    <= STATE_IDLE;
            aer_id   <= '0;
            aer_ts   <= '0;
            aer_last <= 1'b0;
        end else if (frame_take) begin
            drain <= frame_bits;
        end else if (load_next) begin
            drain    <= drain_rest;
            state    <= STATE_SEND;
            aer_id   <= enc_idx;
            aer_ts   <= frame_ts;
            aer_last <= (drain_rest == '0);
        end else if (accept) begin
            state <= STATE_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt <= '0;
        end else if (accept) begin
            evt_cnt <= evt_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed, table-driven bench for spike_aer_encoder plus multi-cycle corner sequences.
module tb_spike_aer_encoder;

    localparam int N = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  spike_valid = '0;
    logic          frame_tick = 1'b0;
    logic          cfg_enable = 1'b0;
    logic          aer_ready = 1'b0;
    logic          aer_valid;
    logic [7:0]    aer_id;
    logic [15:0]   aer_ts;
    logic          aer_last;
    logic          busy;
    logic [31:0]   evt_cnt;
    logic [15:0]   drop_cnt;

    int n_chk = 0;
    int n_fail = 0;

    spike_aer_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spike_valid (spike_valid),
        .frame_tick  (frame_tick),
        .cfg_enable  (cfg_enable),
        .aer_valid   (aer_valid),
        .aer_ready   (aer_ready),
        .aer_id      (aer_id),
        .aer_ts      (aer_ts),
        .aer_last    (aer_last),
        .busy        (busy),
        .evt_cnt     (evt_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] spk;
        logic         tick;
        logic         rdy;
        logic         e_vld;
        logic [7:0]   e_id;
        logic [15:0]  e_ts;
        logic         e_last;
    } vec_t;

    vec_t vecs[25];

    function automatic logic [N-1:0] bits(input int a = -1, input int b = -1, input int c = -1);
        logic [N-1:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        return v;
    endfunction

    function automatic vec_t mk(input logic [N-1:0] spk, input logic tick, input logic vld,
                                input int id = 0, input int ts = 0, input logic last = 1'b0);
        vec_t v;
        v.spk = spk; v.tick = tick; v.rdy = 1'b1;
        v.e_vld = vld; v.e_id = 8'(id); v.e_ts = 16'(ts); v.e_last = last;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_evt(input string nm, input logic vld, input int id, input int ts, input logic last);
        if (vld) chk(nm, {aer_valid, aer_id, aer_ts, aer_last}, {1'b1, 8'(id), 16'(ts), last});
        else     chk(nm, {63'd0, aer_valid}, 64'd0);
    endtask

    task automatic wait_valid(input string nm, input int max_cyc);
        int k;
        k = 0;
        while (!aer_valid && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        if (!aer_valid) chk({nm, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        spike_valid = '0; frame_tick = 1'b0; aer_ready = 1'b0; cfg_enable = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = mk(bits(3, 5), 1'b0, 1'b0);
        vecs[1]  = mk(bits(200), 1'b0, 1'b0);
        vecs[2]  = mk(bits(), 1'b1, 1'b0);
        vecs[3]  = mk(bits(), 1'b0, 1'b1, 3, 0, 1'b0);
        vecs[4]  = mk(bits(), 1'b0, 1'b1, 5, 0, 1'b0);
        vecs[5]  = mk(bits(), 1'b0, 1'b1, 200, 0, 1'b1);
        vecs[6]  = mk(bits(), 1'b0, 1'b0);
        vecs[7]  = mk(bits(7), 1'b0, 1'b0);
        vecs[8]  = mk(bits(7), 1'b0, 1'b0);
        vecs[9]  = mk(bits(7), 1'b0, 1'b0);
        vecs[10] = mk(bits(7), 1'b1, 1'b0);
        vecs[11] = mk(bits(), 1'b0, 1'b1, 7, 1, 1'b1);
        vecs[12] = mk(bits(), 1'b0, 1'b0);
        vecs[13] = mk(bits(9), 1'b1, 1'b0);
        vecs[14] = mk(bits(9), 1'b0, 1'b1, 9, 2, 1'b1);
        vecs[15] = mk(bits(), 1'b0, 1'b0);
        vecs[16] = mk(bits(), 1'b1, 1'b0);
        vecs[17] = mk(bits(), 1'b0, 1'b1, 9, 3, 1'b1);
        // Tick on the same edge as the final accept: that frame is dropped.
        vecs[18] = mk(bits(4), 1'b1, 1'b0);
        vecs[19] = mk(bits(), 1'b0, 1'b0);
        vecs[20] = mk(bits(), 1'b1, 1'b0);
        vecs[21] = mk(bits(), 1'b0, 1'b0);
        vecs[22] = mk(bits(0), 1'b1, 1'b0);
        vecs[23] = mk(bits(), 1'b0, 1'b1, 0, 6, 1'b1);
        vecs[24] = mk(bits(), 1'b0, 1'b0);

        // Reset state
        cfg_enable = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {aer_valid, aer_id, aer_ts, aer_last, busy}, 64'd0);
        chk("reset_counters", {evt_cnt, drop_cnt}, 64'd0);
        do_reset();

        // Table-driven frames
        for (int i = 0; i < 25; i++) begin
            spike_valid = vecs[i].spk;
            frame_tick  = vecs[i].tick;
            aer_ready   = vecs[i].rdy;
            @(negedge clk);
            chk_evt($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_id, vecs[i].e_ts, vecs[i].e_last);
            if (i == 6)  chk("evt_cnt_frame0", 64'(evt_cnt), 64'd3);
            if (i == 18) chk("evt_cnt_after_v18", 64'(evt_cnt), 64'd6);
        end
        spike_valid = '0; frame_tick = 1'b0;
        chk("drop_cnt_same_edge", 64'(drop_cnt), 64'd1);
        chk("evt_cnt_table_end", 64'(evt_cnt), 64'd7);

        // Backpressure: payload held stable for 10 stalled cycles
        do_reset();
        spike_valid = bits(3, 5, 200); frame_tick = 1'b1; aer_ready = 1'b0;
        @(negedge clk);
        spike_valid = '0; frame_tick = 1'b0;
        wait_valid("stall_first", 5);
        for (int k = 0; k < 10; k++) begin
            chk_evt($sformatf("stall_hold%0d", k), 1'b1, 3, 0, 1'b0);
            chk("stall_busy", 64'(busy), 64'd1);
            @(negedge clk);
        end
        aer_ready = 1'b1;
        chk_evt("stall_rel0", 1'b1, 3, 0, 1'b0);
        @(negedge clk);
        chk_evt("stall_rel1", 1'b1, 5, 0, 1'b0);
        @(negedge clk);
        chk_evt("stall_rel2", 1'b1, 200, 0, 1'b1);
        @(negedge clk);
        chk_evt("stall_done", 1'b0, 0, 0, 1'b0);
        chk("stall_evt_cnt", 64'(evt_cnt), 64'd3);
        chk("stall_busy_end", 64'(busy), 64'd0);

        // Overrun: full frame stalled, second frame dropped, ts keeps advancing
        do_reset();
        spike_valid = '1; frame_tick = 1'b1; aer_ready = 1'b0;
        @(negedge clk);
        spike_valid = bits(1); frame_tick = 1'b1;
        @(negedge clk);
        spike_valid = '0; frame_tick = 1'b0;
        chk("overrun_drop", 64'(drop_cnt), 64'd1);
        chk_evt("overrun_head", 1'b1, 0, 0, 1'b0);
        aer_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            chk_evt($sformatf("full_evt%0d", k), 1'b1, k, 0, k == N - 1);
            @(negedge clk);
        end
        chk_evt("full_done", 1'b0, 0, 0, 1'b0);
        spike_valid = bits(2); frame_tick = 1'b1;
        @(negedge clk);
        spike_valid = '0; frame_tick = 1'b0;
        wait_valid("after_drop", 5);
        chk_evt("after_drop_ts", 1'b1, 2, 2, 1'b1);
        @(negedge clk);
        chk("overrun_evt_cnt", 64'(evt_cnt), 64'd257);
        chk("overrun_drop_end", 64'(drop_cnt), 64'd1);

        // Asynchronous reset in the middle of a drain
        spike_valid = bits(1, 2, 3); frame_tick = 1'b1; aer_ready = 1'b1;
        @(negedge clk);
        spike_valid = '0; frame_tick = 1'b0;
        wait_valid("mid_first", 5);
        @(negedge clk);
        chk_evt("mid_second", 1'b1, 2, 3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid_busy", {62'd0, aer_valid, busy}, 64'd0);
        chk("async_rst_counters", {evt_cnt, drop_cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Disabled: spikes and ticks ignored, ts_cnt frozen
        cfg_enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            spike_valid = bits(10); frame_tick = k[0];
            @(negedge clk);
            chk("disabled_idle", {62'd0, aer_valid, busy}, 64'd0);
        end
        cfg_enable = 1'b1;
        spike_valid = bits(11); frame_tick = 1'b1;
        @(negedge clk);
        spike_valid = '0; frame_tick = 1'b0;
        wait_valid("reenable", 5);
        chk_evt("reenable_evt", 1'b1, 11, 0, 1'b1);
        @(negedge clk);
        chk_evt("reenable_done", 1'b0, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
